// File: rtl/bcd_chain_ctrl.sv
// bcd_chain_ctrl: run/pause/clear sequencer for a cascaded BCD counter with lap hold; define BCD_CHAIN_WRAP_EN to wrap on overflow instead of saturating into DONE
module bcd_chain_ctrl #(
  parameter int DIGITS = 4,
  parameter int PRESCALE = 10,
  parameter int PRESCALE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] bcd,
  output logic [4*DIGITS-1:0] disp,
  output logic                running,
  output logic                tick,
  output logic                overflow
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
`ifdef BCD_CHAIN_WRAP_EN
  localparam bit wrap_en = 1'b1;
`else
  localparam bit wrap_en = 1'b0;
`endif
  state_t state, state_n;
  logic [PRESCALE_W-1:0] presc, presc_n;
  logic [4*DIGITS-1:0] bcd_n, inc;
  logic [DIGITS:0] carry;
  logic hold, hold_n, overflow_n, ovf_evt, sat;
  assign tick = state == RUN && presc == PRESCALE_W'(PRESCALE - 1);
  assign carry[0] = tick;
  // a digit advances only when the tick ripples through every lower digit sitting at 9
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] d;
    assign d = bcd[4*i +: 4];
    assign inc[4*i +: 4] = !carry[i] ? d : d == 4'd9 ? 4'd0 : d + 4'd1;
    assign carry[i+1] = carry[i] && d == 4'd9;
  end
  assign ovf_evt = carry[DIGITS];
  assign sat = ovf_evt && !wrap_en;
  always_comb begin
    state_n = state;
    hold_n = (state == RUN || state == PAUSE) && lap ? !hold : hold;
    presc_n = state == RUN ? (tick ? '0 : presc + 1'b1) : presc;
    bcd_n = state == RUN && !sat ? inc : bcd;
    overflow_n = wrap_en ? ovf_evt : overflow || ovf_evt;
    if (clear) begin
      state_n = IDLE;
      hold_n = 1'b0;
      presc_n = '0;
      bcd_n = '0;
      overflow_n = 1'b0;
    end else if (sat)
      state_n = DONE;
    else if (stop)
      state_n = state == RUN ? PAUSE : state;
    else if (start && (state == IDLE || state == PAUSE)) begin
      state_n = RUN;
      presc_n = state == IDLE ? '0 : presc;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      presc <= '0;
      bcd <= '0;
      disp <= '0;
      hold <= 1'b0;
      overflow <= 1'b0;
      running <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      bcd <= bcd_n;
      disp <= hold_n ? disp : bcd_n;
      hold <= hold_n;
      overflow <= overflow_n;
      running <= state_n == RUN;
    end
  end
endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// tb_bcd_chain_ctrl: directed and random stimulus checked against an integer-count reference model
module tb_bcd_chain_ctrl;
  localparam int D = 2, P = 3, MAX = 99;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic clk = 1'b0, reset, start, stop, clear, lap;
  logic [4*D-1:0] bcd, disp;
  logic running, tick, overflow;
  int errors = 0, checks = 0;
  int m_state, m_cnt, m_pre, m_frozen;
  bit m_hold, m_ovf;
  always #5 clk = ~clk;
  bcd_chain_ctrl #(.DIGITS(D), .PRESCALE(P), .PRESCALE_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .bcd(bcd), .disp(disp), .running(running), .tick(tick), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  task automatic model_edge(input bit rs, st, sp, cl, lp);
    bit t, sat;
    if (!rs) begin
      m_state = M_IDLE; m_cnt = 0; m_pre = 0; m_hold = 0; m_ovf = 0; m_frozen = 0;
      return;
    end
    t = m_state == M_RUN && m_pre == P - 1;
    sat = 0;
    if (lp && (m_state == M_RUN || m_state == M_PAUSE)) begin
      if (!m_hold) m_frozen = m_cnt;
      m_hold = !m_hold;
    end
    if (m_state == M_RUN) m_pre = t ? 0 : m_pre + 1;
`ifdef BCD_CHAIN_WRAP_EN
    m_ovf = t && m_cnt == MAX;
    if (t) m_cnt = (m_cnt + 1) % (MAX + 1);
`else
    sat = t && m_cnt == MAX;
    if (sat) m_ovf = 1;
    else if (t) m_cnt++;
`endif
    if (cl) begin
      m_state = M_IDLE; m_cnt = 0; m_pre = 0; m_hold = 0; m_ovf = 0;
    end else if (sat) m_state = M_DONE;
    else if (sp) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
    end else if (st && m_state == M_IDLE) begin
      m_state = M_RUN; m_pre = 0;
    end else if (st && m_state == M_PAUSE) m_state = M_RUN;
  endtask
  task automatic step(input bit rs, st, sp, cl, lp);
    reset = rs; start = st; stop = sp; clear = cl; lap = lp;
    check("tick", tick, m_state == M_RUN && m_pre == P - 1);
    @(posedge clk);
    model_edge(rs, st, sp, cl, lp);
    #1;
    check("bcd", bcd, to_bcd(m_cnt));
    check("disp", disp, m_hold ? to_bcd(m_frozen) : to_bcd(m_cnt));
    check("running", running, m_state == M_RUN);
    check("overflow", overflow, m_ovf);
    for (int i = 0; i < D; i++) check("nibble_le9", bcd[4*i +: 4] <= 4'd9, 1);
  endtask
  task automatic run(input int n);
    repeat (n) step(1, 0, 0, 0, 0);
  endtask
  initial begin
    int n;
    reset = 0; start = 0; stop = 0; clear = 0; lap = 0;
    repeat (2) @(posedge clk);
    #1;
    model_edge(0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    check("rst_bcd", bcd, 0);
    check("rst_disp", disp, 0);
    check("rst_running", running, 0);
    step(1, 1, 0, 0, 0);
    check("run_after_reset", running, 1);
    check("no_tick_yet", tick, 0);
    run(2);
    check("first_tick", tick, 1);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    run(30);
    check("cascade_10", bcd, 8'h10);
    run(27);
    check("cascade_19", bcd, 8'h19);
    run(3);
    check("cascade_20", bcd, 8'h20);
    run(1);
    step(1, 0, 1, 0, 0);
    run(20);
    check("paused_bcd", bcd, 8'h20);
    check("paused_running", running, 0);
    step(1, 1, 0, 0, 0);
    check("resume_tick", tick, 1);
    run(1);
    check("resume_bcd", bcd, 8'h21);
    run(2);
    step(1, 0, 1, 0, 0);
    check("stop_tick_bcd", bcd, 8'h22);
    check("stop_tick_running", running, 0);
    step(1, 1, 1, 0, 0);
    check("stop_start_pause", running, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    check("clear_start_bcd", bcd, 0);
    check("clear_start_running", running, 0);
    step(1, 0, 0, 0, 1);
    check("lap_idle", disp, 0);
    step(1, 1, 0, 0, 0);
    run(15);
    check("lap_pre", bcd, 8'h05);
    step(1, 0, 0, 0, 1);
    run(21);
    check("lap_hold_disp", disp, 8'h05);
    check("lap_hold_bcd", bcd, 8'h12);
    step(1, 0, 0, 0, 1);
    check("lap_release", disp, 8'h12);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    for (n = 0; n < 400 && !(m_cnt == MAX && m_pre == P - 1); n++) run(1);
    check("reach_99", n < 400, 1);
    run(1);
`ifdef BCD_CHAIN_WRAP_EN
    check("wrap_bcd", bcd, 0);
    check("wrap_ovf", overflow, 1);
    check("wrap_running", running, 1);
    run(1);
    check("wrap_ovf_pulse", overflow, 0);
`else
    check("sat_bcd", bcd, 8'h99);
    check("sat_ovf", overflow, 1);
    check("sat_running", running, 0);
    step(1, 1, 0, 0, 0);
    check("done_start", running, 0);
    check("done_sticky", overflow, 1);
    step(1, 0, 0, 1, 0);
    check("done_clear_bcd", bcd, 0);
    check("done_clear_ovf", overflow, 0);
`endif
    repeat (4000)
      step($urandom_range(0, 255) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_chain_ctrl.md
Name: bcd_chain_ctrl

Overview:
- Run/pause/clear sequencer for a cascade of DIGITS decade (BCD 0-9) digit counters.
- Generates the per-digit enable chain from a prescaled count tick; a digit advances only when every lower digit is at 9.
- Provides a lap-hold display register and overflow signalling.
- Sits between front-panel command pulses and the 7-segment/BCD display path.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1-8).
- PRESCALE, 10, clk cycles per count tick (>=1).
- PRESCALE_W, 4, prescaler width; must satisfy 2^PRESCALE_W >= PRESCALE.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  command pulse: begin or resume counting.
- stop  input  1  command pulse: pause counting.
- clear  input  1  command pulse: zero all digits and return to IDLE.
- lap  input  1  command pulse: toggle display hold.
- bcd  output  4*DIGITS  live digit values; digit 0 is the LSD at [3:0].
- disp  output  4*DIGITS  display value; follows bcd unless held.
- running  output  1  high in RUN.
- tick  output  1  one-cycle count strobe.
- overflow  output  1  overflow flag (see below).

Behaviour:
- Interface: reset is synchronous and active-low; clock is clk.
- Reset (reset==0 at posedge):
  - state=IDLE, all digits=0, disp=0, prescaler=0, hold=0.
  - running=0, tick=0, overflow=0.
  - Reset overrides all commands.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority in one cycle: clear > stop > start. lap is independent of the others.
- Transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE.
  - PAUSE: start -> RUN.
  - Any state: clear -> IDLE, digits=0, prescaler=0, hold=0, overflow=0.
  - DONE: left only by clear or reset. start and stop are ignored.
  - start in RUN and stop in IDLE/PAUSE/DONE are no-ops.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN and wraps to 0.
  - Holds its value in PAUSE, so resume continues the partial period.
  - Zeroed on IDLE->RUN.
- tick:
  - Combinational: state==RUN && prescaler==PRESCALE-1.
  - With PRESCALE=1, tick is high every RUN cycle.
  - First tick occurs PRESCALE cycles after the start edge.
- Digit update on a tick edge:
  - Digit i increments iff all digits j<i ==9.
  - A digit at 9 that increments becomes 0; digits never hold 10-15.
- Terminal count: a tick while all digits==9 is the overflow event (see Optional Feature).
- stop coincident with tick: that tick's increment is applied, then the block enters PAUSE.
- lap:
  - Each lap pulse in RUN or PAUSE toggles hold. lap is ignored in IDLE and DONE.
  - When hold=0, disp is registered from bcd's next value, i.e. disp==bcd every cycle.
  - When hold=1, disp is frozen at the bcd value latched on the lap edge that set hold.
  - Releasing hold makes disp==bcd on the following cycle.
- running is registered and equals (state==RUN).

Optional Feature:
- Macro: BCD_CHAIN_WRAP_EN.
- Defined:
  - The overflow event wraps all digits to 0 and the block stays in RUN.
  - overflow is a one-cycle pulse on the cycle after the wrap edge.
  - DONE is unreachable.
- Undefined:
  - The overflow event leaves digits saturated at all-9 and moves to DONE; running drops to 0.
  - overflow is a sticky level, set on that edge and cleared only by clear or reset.

Test Plan:
- Reset with DIGITS=2, PRESCALE=2: hold reset=0 with start=1 for 3 cycles -> bcd=0x00, disp=0x00, running=0, overflow=0. Release -> RUN on the next edge, first tick 2 cycles later.
- Cascade: DIGITS=2, PRESCALE=1, run 10 ticks -> bcd 0x00..0x09 then 0x10. tick at value 0x19 -> 0x20. Assert no nibble ever exceeds 9.
- Pause/resume: PRESCALE=4, stop asserted 2 cycles into a period -> bcd unchanged while paused for 20 cycles. After start, next tick arrives 2 cycles later, not 4.
- Overflow, DIGITS=2, PRESCALE=1:
  - Without macro: from 0x99, next tick -> bcd stays 0x99, state DONE, overflow=1 sticky, start ignored; clear -> 0x00, IDLE, overflow=0.
  - With BCD_CHAIN_WRAP_EN: 0x99 -> 0x00, one-cycle overflow pulse, running stays 1.
- Lap: RUN at bcd=0x05, lap pulse -> disp holds 0x05 while bcd advances to 0x12. Second lap -> disp==bcd the next cycle. lap in IDLE -> no effect.
- Simultaneous commands: clear+start in RUN -> IDLE with digits 0. stop+start in PAUSE -> remains PAUSE. stop coincident with tick at 0x09 -> bcd=0x10, state PAUSE.
